door_input_cond: RTL and testbench

Input conditioning stage directly upstream of the door controller FSM. It takes the four raw, asynchronous door inputs (two push-buttons and two end-position sensors) and synchronizes each one into the clk2m domain. It then debounces each input with a per-channel stability counter and delivers clean levels, one-cycle press pulses and conflict/fault flags. The FSM then only ever sees stable, mutually consistent inputs.

---
 rtl/door_input_cond.sv | 67 ++++++
 tb/tb_door_input_cond.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/door_input_cond.sv
// door_input_cond: synchronizes and debounces the four raw door inputs,
// then masks conflicting key levels and inconsistent end-position sensors.
module door_input_cond #(
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic key_up_raw,
  input  logic key_down_raw,
  input  logic sense_up_raw,
  input  logic sense_down_raw,
  output logic key_up,
  output logic key_down,
  output logic key_up_p,
  output logic key_down_p,
  output logic sense_up,
  output logic sense_down,
  output logic key_conflict,
  output logic sensor_fault
);
  // channel order: 0 key_up, 1 key_down, 2 sense_up, 3 sense_down
  logic [3:0] w_raw, r_s1, r_s2, w_deb, r_deb_d, w_rise;
  assign w_raw = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb_d <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= w_deb;
    end
  end
  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_ch
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;
      // any cycle where the synchronized level matches deb restarts qualification
      always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
          r_deb <= 1'b0;
          r_cnt <= '0;
        end else if (r_s2[i] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_deb <= r_s2[i];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_deb[i] = r_deb;
    end
  endgenerate
  assign w_rise       = w_deb & ~r_deb_d;
  assign key_conflict = w_deb[0] & w_deb[1];
  assign sensor_fault = w_deb[2] & w_deb[3];
  assign key_up       = w_deb[0] & ~key_conflict;
  assign key_down     = w_deb[1] & ~key_conflict;
  assign key_up_p     = w_rise[0] & ~key_conflict;
  assign key_down_p   = w_rise[1] & ~key_conflict;
  assign sense_up     = w_deb[2] & ~sensor_fault;
  assign sense_down   = w_deb[3] & ~sensor_fault;
endmodule

// File: tb/tb_door_input_cond.sv
// tb_door_input_cond: directed vectors for door_input_cond with DEB_CYCLES=4.
// Outputs compared as {key_up,key_down,key_up_p,key_down_p,sense_up,sense_down,key_conflict,sensor_fault}.
module tb_door_input_cond;
  logic clk2m = 1'b0;
  logic rst_n = 1'b0;
  logic key_up_raw, key_down_raw, sense_up_raw, sense_down_raw;
  logic key_up, key_down, key_up_p, key_down_p, sense_up, sense_down, key_conflict, sensor_fault;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] raw;
    int         cyc;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  door_input_cond #(.DEB_CYCLES(4)) dut (
    .clk2m(clk2m), .rst_n(rst_n),
    .key_up_raw(key_up_raw), .key_down_raw(key_down_raw),
    .sense_up_raw(sense_up_raw), .sense_down_raw(sense_down_raw),
    .key_up(key_up), .key_down(key_down), .key_up_p(key_up_p), .key_down_p(key_down_p),
    .sense_up(sense_up), .sense_down(sense_down),
    .key_conflict(key_conflict), .sensor_fault(sensor_fault)
  );

  always #5 clk2m = ~clk2m;

  function automatic logic [7:0] outs();
    return {key_up, key_down, key_up_p, key_down_p, sense_up, sense_down, key_conflict, sensor_fault};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    checks++;
    if (outs() !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, outs(), exp);
    end
  endtask

  // raw order {key_up, key_down, sense_up, sense_down}
  task automatic drive(input logic [3:0] r);
    {key_up_raw, key_down_raw, sense_up_raw, sense_down_raw} = r;
  endtask

  task automatic run(input logic [3:0] r, input int n);
    drive(r);
    repeat (n) @(posedge clk2m);
    @(negedge clk2m);
  endtask

  task automatic reset_cycle(input logic [3:0] r);
    rst_n = 1'b0;
    drive(r);
    repeat (2) @(negedge clk2m);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset held with every input high, then released with all high
    drive(4'b1111);
    repeat (3) @(negedge clk2m);
    check("reset_hold", 8'h00);
    rst_n = 1'b1;
    run(4'b1111, 5);
    check("all_high_pre", 8'h00);
    run(4'b1111, 1);
    check("all_high_conflict_fault", 8'b0000_0011);
    // asynchronous assertion clears outputs between edges
    rst_n = 1'b0;
    #1 check("async_reset", 8'h00);
    drive(4'b1000);
    repeat (2) @(negedge clk2m);
    rst_n = 1'b1;
    run(4'b1000, 5);
    check("rst_req_pre", 8'h00);
    run(4'b1000, 1);
    check("rst_req_rise", 8'b1010_0000);
    run(4'b1000, 1);
    check("rst_req_pulse_end", 8'b1000_0000);
    // reset mid-count on sense_down
    reset_cycle(4'b0000);
    run(4'b0001, 4);
    check("midcnt_partial", 8'h00);
    rst_n = 1'b0;
    #1 check("midcnt_reset", 8'h00);
    repeat (2) @(negedge clk2m);
    rst_n = 1'b1;
    run(4'b0001, 5);
    check("midcnt_full_pre", 8'h00);
    run(4'b0001, 1);
    check("midcnt_full_rise", 8'b0000_0100);
    reset_cycle(4'b0000);

    // key_up press and release debounce
    tbl.push_back('{4'b1000, 5, 8'b0000_0000});
    tbl.push_back('{4'b1000, 1, 8'b1010_0000});
    tbl.push_back('{4'b1000, 1, 8'b1000_0000});
    tbl.push_back('{4'b0000, 3, 8'b1000_0000});
    tbl.push_back('{4'b1000, 4, 8'b1000_0000});
    tbl.push_back('{4'b0000, 5, 8'b1000_0000});
    tbl.push_back('{4'b0000, 1, 8'b0000_0000});
    tbl.push_back('{4'b0000, 4, 8'b0000_0000});
    // key_down bounce: 3 high, 1 low, then steady high
    tbl.push_back('{4'b0100, 3, 8'b0000_0000});
    tbl.push_back('{4'b0000, 1, 8'b0000_0000});
    tbl.push_back('{4'b0100, 5, 8'b0000_0000});
    tbl.push_back('{4'b0100, 1, 8'b0101_0000});
    tbl.push_back('{4'b0100, 1, 8'b0100_0000});
    tbl.push_back('{4'b0100, 3, 8'b0100_0000});
    // key_down held, key_up accepted: conflict, then key_down released
    tbl.push_back('{4'b1100, 5, 8'b0100_0000});
    tbl.push_back('{4'b1100, 1, 8'b0000_0010});
    tbl.push_back('{4'b1100, 2, 8'b0000_0010});
    tbl.push_back('{4'b1000, 5, 8'b0000_0010});
    tbl.push_back('{4'b1000, 1, 8'b1000_0000});
    tbl.push_back('{4'b1000, 2, 8'b1000_0000});
    tbl.push_back('{4'b0000, 5, 8'b1000_0000});
    tbl.push_back('{4'b0000, 1, 8'b0000_0000});
    // both keys accepted on the same edge
    tbl.push_back('{4'b1100, 5, 8'b0000_0000});
    tbl.push_back('{4'b1100, 1, 8'b0000_0010});
    tbl.push_back('{4'b0000, 6, 8'b0000_0000});
    // sensor fault and recovery
    tbl.push_back('{4'b0011, 5, 8'b0000_0000});
    tbl.push_back('{4'b0011, 1, 8'b0000_0001});
    tbl.push_back('{4'b0011, 3, 8'b0000_0001});
    tbl.push_back('{4'b0001, 5, 8'b0000_0001});
    tbl.push_back('{4'b0001, 1, 8'b0000_0100});
    tbl.push_back('{4'b0010, 5, 8'b0000_0100});
    tbl.push_back('{4'b0010, 1, 8'b0000_1000});
    tbl.push_back('{4'b0000, 6, 8'b0000_0000});

    for (int k = 0; k < tbl.size(); k++) begin
      run(tbl[k].raw, tbl[k].cyc);
      check($sformatf("vec%0d", k), tbl[k].exp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
